conv1d_stream_engine: RTL and testbench

//  Parametrised streaming 1-D convolution layer: accepts one Image/Filter pair per cycle,

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_mac.sv | 46 ++++
 rtl/conv1d_stream_engine.sv | 127 ++++++++++++
 tb/tb_conv1d_stream_engine.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the streaming 1-D convolution engine.
package conv_pkg;

   typedef enum logic [1:0] {IDLE, CONV, DRAIN} state_t;

   // Wide enough that KERNEL full-scale products can be summed without overflow.
   function automatic int acc_width(input int data_w, input int kernel);
      return 2 * data_w + $clog2(kernel);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate with signed/unsigned product extension and clear-on-last-tap.
module conv_mac #(
   parameter int DATA_W = 4,
   parameter int ACC_W  = 10,
   parameter int SIGNED = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc,
   output logic [ACC_W-1:0]  sum
);

   logic [ACC_W-1:0] prod_ext;

   generate
      if (SIGNED != 0) begin : g_signed
         logic signed [DATA_W-1:0]   a_s;
         logic signed [DATA_W-1:0]   b_s;
         logic signed [2*DATA_W-1:0] prod_s;
         assign a_s      = a;
         assign b_s      = b;
         assign prod_s   = a_s * b_s;
         assign prod_ext = ACC_W'(prod_s);
      end else begin : g_unsigned
         logic [2*DATA_W-1:0] prod_u;
         assign prod_u   = a * b;
         assign prod_ext = ACC_W'(prod_u);
      end
   endgenerate

   // sum already includes this cycle's product, so the last tap can be stored without waiting.
   assign sum = acc + prod_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (en) begin
         acc <= clr ? '0 : sum;
      end
   end

endmodule

// File: rtl/conv1d_stream_engine.sv
// Streaming 1-D convolution: MAC per window, result FIFO of NUM_OUT entries, pop-on-ReadEn.
module conv1d_stream_engine
   import conv_pkg::*;
#(
   parameter int DATA_W  = 4,
   parameter int KERNEL  = 3,
   parameter int NUM_OUT = 5,
   parameter int SIGNED  = 0,
   parameter int RELU    = 0,
   parameter int ACC_W   = acc_width(DATA_W, KERNEL)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Start,
   input  logic [DATA_W-1:0] Image,
   input  logic [DATA_W-1:0] Filter,
   input  logic              ReadEn,
   output logic [ACC_W-1:0]  ConvResult,
   output logic              ResultValid,
   output logic              Busy,
   output logic              Done
);

   localparam int PTR_W = ptr_width(NUM_OUT);
   localparam int TAP_W = ptr_width(KERNEL);
   localparam int CNT_W = $clog2(NUM_OUT + 1);

   state_t            state, state_nxt;
   logic [TAP_W-1:0]  tap_cnt;
   logic [PTR_W-1:0]  win_cnt;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [ACC_W-1:0]  fifo_mem [NUM_OUT];
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  sum;
   logic              accept;
   logic              wr_en;
   logic              rd_en;
   logic              win_last;

   function automatic logic [ACC_W-1:0] relu_clamp(input logic [ACC_W-1:0] v);
      if (RELU != 0 && SIGNED != 0 && v[ACC_W-1]) return '0;
      return v;
   endfunction

   assign accept   = Start && (state == IDLE || state == CONV);
   assign wr_en    = accept && (tap_cnt == TAP_W'(KERNEL - 1));
   assign rd_en    = ReadEn && (count != '0);
   assign win_last = (win_cnt == PTR_W'(NUM_OUT - 1));
   assign Busy     = (state == CONV);
   assign Done     = (state == DRAIN);

   conv_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .SIGNED (SIGNED)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .clr   (wr_en),
      .a     (Image),
      .b     (Filter),
      .acc   (acc),
      .sum   (sum)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (wr_en && win_last) state_nxt = DRAIN;
            else if (Start)        state_nxt = CONV;
         end
         CONV: begin
            if (wr_en && win_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (count == '0 && !Start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tap_cnt <= '0;
         win_cnt <= '0;
         wr_ptr  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            tap_cnt <= wr_en ? '0 : tap_cnt + 1'b1;
         end
         if (wr_en) begin
            win_cnt <= win_cnt + 1'b1;
            wr_ptr  <= (wr_ptr == PTR_W'(NUM_OUT - 1)) ? '0 : wr_ptr + 1'b1;
         end else if (state == DRAIN && state_nxt == IDLE) begin
            win_cnt <= '0;
         end
      end
   end

   // Storage carries no reset: validity is tracked entirely by count.
   always_ff @(posedge clk) begin
      if (wr_en) fifo_mem[wr_ptr] <= relu_clamp(sum);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr      <= '0;
         count       <= '0;
         ConvResult  <= '0;
         ResultValid <= 1'b0;
      end else begin
         ResultValid <= rd_en;
         if (rd_en) begin
            ConvResult <= fifo_mem[rd_ptr];
            rd_ptr     <= (rd_ptr == PTR_W'(NUM_OUT - 1)) ? '0 : rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

endmodule

// File: tb/tb_conv1d_stream_engine.sv
// Directed bench: default, signed+ReLU and signed engines share one stimulus stream.
module tb_conv1d_stream_engine;

   logic       clk;
   logic       rst_n;
   logic       Start;
   logic [3:0] Image;
   logic [3:0] Filter;
   logic       ReadEn;

   logic [9:0] res_u,  res_r,  res_s;
   logic       vld_u,  vld_r,  vld_s;
   logic       busy_u, busy_r, busy_s;
   logic       done_u, done_r, done_s;

   int n_tests = 0;
   int n_fail  = 0;

   conv1d_stream_engine u_dut (
      .clk(clk), .rst_n(rst_n), .Start(Start), .Image(Image), .Filter(Filter),
      .ReadEn(ReadEn), .ConvResult(res_u), .ResultValid(vld_u), .Busy(busy_u), .Done(done_u)
   );

   conv1d_stream_engine #(.SIGNED(1), .RELU(1)) u_dut_relu (
      .clk(clk), .rst_n(rst_n), .Start(Start), .Image(Image), .Filter(Filter),
      .ReadEn(ReadEn), .ConvResult(res_r), .ResultValid(vld_r), .Busy(busy_r), .Done(done_r)
   );

   conv1d_stream_engine #(.SIGNED(1), .RELU(0)) u_dut_sgn (
      .clk(clk), .rst_n(rst_n), .Start(Start), .Image(Image), .Filter(Filter),
      .ReadEn(ReadEn), .ConvResult(res_s), .ResultValid(vld_s), .Busy(busy_s), .Done(done_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic st, input logic [3:0] img, input logic [3:0] flt, input logic rd);
      Start  = st;
      Image  = img;
      Filter = flt;
      ReadEn = rd;
      @(posedge clk);
      #1;
      Start  = 1'b0;
      ReadEn = 1'b0;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      Start  = 1'b0;
      ReadEn = 1'b0;
      Image  = '0;
      Filter = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Pair k of the standard stream: window k/3 uses Image w+1..w+3, Filter 1..3.
   task automatic stream_pair(input int k, input logic rd);
      step(1'b1, 4'((k / 3) + (k % 3) + 1), 4'((k % 3) + 1), rd);
   endtask

   task automatic read_expect(input string tag, input logic [9:0] exp);
      step(1'b0, 4'd0, 4'd0, 1'b1);
      check({tag, "_vld"}, 32'(vld_u), 32'd1);
      check({tag, "_res"}, 32'(res_u), 32'(exp));
   endtask

   logic [9:0] exp_win [5];

   initial begin
      exp_win[0] = 10'd14; exp_win[1] = 10'd20; exp_win[2] = 10'd26;
      exp_win[3] = 10'd32; exp_win[4] = 10'd38;

      // Reset state
      rst_n = 1'b0; Start = 1'b0; ReadEn = 1'b0; Image = '0; Filter = '0;
      #12;
      check("rst_res",  32'(res_u),  32'd0);
      check("rst_vld",  32'(vld_u),  32'd0);
      check("rst_busy", 32'(busy_u), 32'd0);
      check("rst_done", 32'(done_u), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Test 1: plain stream then five reads
      stream_pair(0, 1'b0);
      check("t1_busy", 32'(busy_u), 32'd1);
      for (int k = 1; k < 15; k++) stream_pair(k, 1'b0);
      check("t1_done", 32'(done_u), 32'd1);
      check("t1_busy_off", 32'(busy_u), 32'd0);
      for (int i = 0; i < 5; i++) read_expect($sformatf("t1_rd%0d", i), exp_win[i]);
      step(1'b0, 4'd0, 4'd0, 1'b0);
      check("t1_idle", 32'(done_u), 32'd0);

      // Test 2: Start low for 2 cycles after tap 0 of window 2, garbage on inputs
      do_reset();
      for (int k = 0; k < 7; k++) stream_pair(k, 1'b0);
      step(1'b0, 4'hF, 4'hF, 1'b0);
      step(1'b0, 4'hF, 4'hF, 1'b0);
      for (int k = 7; k < 15; k++) stream_pair(k, 1'b0);
      check("t2_done", 32'(done_u), 32'd1);
      for (int i = 0; i < 5; i++) read_expect($sformatf("t2_rd%0d", i), exp_win[i]);
      step(1'b0, 4'd0, 4'd0, 1'b1);
      check("t2_extra_vld", 32'(vld_u), 32'd0);
      check("t2_extra_hold", 32'(res_u), 32'd38);

      // Test 3: reads while computing, including a same-cycle write+read
      do_reset();
      for (int k = 0; k < 3; k++) stream_pair(k, 1'b0);
      stream_pair(3, 1'b1);
      check("t3_rd0_vld", 32'(vld_u), 32'd1);
      check("t3_rd0_res", 32'(res_u), 32'd14);
      check("t3_rd0_busy", 32'(busy_u), 32'd1);
      for (int k = 4; k < 8; k++) stream_pair(k, 1'b0);
      stream_pair(8, 1'b1);
      check("t3_rd1_res", 32'(res_u), 32'd20);
      for (int k = 9; k < 15; k++) stream_pair(k, 1'b0);
      read_expect("t3_rd2", 10'd26);
      read_expect("t3_rd3", 10'd32);
      read_expect("t3_rd4", 10'd38);
      step(1'b0, 4'd0, 4'd0, 1'b1);
      check("t3_rd5_vld", 32'(vld_u), 32'd0);

      // Test 4: signed with and without ReLU; -8*7*3 = -168, then 2*3*3 = 18
      do_reset();
      for (int k = 0; k < 3; k++) step(1'b1, 4'h8, 4'd7, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, 4'd2, 4'd3, 1'b0);
      step(1'b0, 4'd0, 4'd0, 1'b1);
      check("t4_relu_vld", 32'(vld_r), 32'd1);
      check("t4_relu_neg", 32'(res_r), 32'd0);
      check("t4_sgn_neg",  32'(res_s), 32'd856);
      check("t4_uns_168",  32'(res_u), 32'd168);
      step(1'b0, 4'd0, 4'd0, 1'b1);
      check("t4_relu_pos", 32'(res_r), 32'd18);
      check("t4_sgn_pos",  32'(res_s), 32'd18);

      // Test 5: full-scale unsigned (15*15*3 = 675); signed view is (-1)*(-1)*3 = 3
      do_reset();
      for (int k = 0; k < 3; k++) step(1'b1, 4'hF, 4'hF, 1'b0);
      step(1'b0, 4'd0, 4'd0, 1'b1);
      check("t5_max", 32'(res_u), 32'd675);
      check("t5_sgn", 32'(res_s), 32'd3);

      // Test 6: async reset during window 3
      do_reset();
      for (int k = 0; k < 10; k++) stream_pair(k, 1'b0);
      step(1'b0, 4'd0, 4'd0, 1'b1);
      check("t6_pre_res", 32'(res_u), 32'd14);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_res",  32'(res_u),  32'd0);
      check("t6_rst_busy", 32'(busy_u), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b0, 4'd0, 4'd0, 1'b1);
      check("t6_empty_vld", 32'(vld_u), 32'd0);
      check("t6_idle_done", 32'(done_u), 32'd0);
      for (int k = 0; k < 15; k++) stream_pair(k, 1'b0);
      for (int i = 0; i < 5; i++) read_expect($sformatf("t6_rd%0d", i), exp_win[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
